// File: rtl/fp_sort_pkg.sv
// Shared definitions for the float quicksort blocks: default key geometry,
// partition FSM state encoding and strobe-decode helpers.
package fp_sort_pkg;

  localparam int unsigned N_DEF  = 23;
  localparam int unsigned M_DEF  = 8;
  localparam int unsigned L_DEF  = N_DEF + M_DEF + 1;
  localparam int unsigned AW_DEF = 8;

  localparam logic [L_DEF-1:0] POS_ZERO = 32'h0000_0000;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    RDP  = 4'd1,
    WP   = 4'd2,
    RDJ  = 4'd3,
    WJ   = 4'd4,
    RDS  = 4'd5,
    WS   = 4'd6,
    WRS  = 4'd7,
    WRJ  = 4'd8,
    RDF  = 4'd9,
    WF   = 4'd10,
    WRF1 = 4'd11,
    WRF2 = 4'd12,
    DONE = 4'd13
  } state_e;

  function automatic logic is_read_state(input state_e st);
    return (st == RDP) || (st == RDJ) || (st == RDS) || (st == RDF);
  endfunction

  function automatic logic is_write_state(input state_e st);
    return (st == WRS) || (st == WRJ) || (st == WRF1) || (st == WRF2);
  endfunction

endpackage

// File: rtl/Agrt.sv
// Float greater-than comparator: agrt = (inp1 > inp2) under sign-magnitude
// ordering, so -0 < +0 and NaN patterns simply order by their bits.
module Agrt #(
  parameter int N = 23,
  parameter int M = 8
) (
  input  logic [N+M:0] inp1,
  input  logic [N+M:0] inp2,
  output logic         agrt
);

  // Sign decides first; among negatives a larger magnitude is the smaller value.
  always_comb begin
    if (inp1[N+M] != inp2[N+M]) begin
      agrt = ~inp1[N+M];
    end else if (inp1[N+M] == 1'b0) begin
      agrt = (inp1[N+M-1:0] > inp2[N+M-1:0]);
    end else begin
      agrt = (inp1[N+M-1:0] < inp2[N+M-1:0]);
    end
  end

endmodule

// File: rtl/fp_partition.sv
// One Lomuto partition of mem[lo..hi] around pivot mem[hi] over a single-port
// synchronous RAM; reports the pivot's final index with a done pulse.
module fp_partition
  import fp_sort_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int M  = M_DEF,
  parameter int L  = N + M + 1,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] lo,
  input  logic [AW-1:0] hi,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] p_idx,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [L-1:0]  mem_wdata,
  input  logic [L-1:0]  mem_rdata
);

  localparam logic [AW-1:0] ONE = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] lo_q, lo_d, hi_q, hi_d, j_q, j_d, s_q, s_d, p_idx_q, p_idx_d;
  logic [L-1:0]  pivot_q, pivot_d, a_j_q, a_j_d, a_s_q, a_s_d;
  logic          busy_q, busy_d, done_q, done_d, re_q, re_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [L-1:0]  wdata_q, wdata_d;
  logic [L-1:0]  cmp_in1;
  logic          agrt;

  // The key under test arrives on mem_rdata in WJ, before a_j is loaded.
  assign cmp_in1 = (state_q == WJ) ? mem_rdata : a_j_q;

  Agrt #(.N(N), .M(M)) u_agrt (
    .inp1(cmp_in1),
    .inp2(pivot_q),
    .agrt(agrt)
  );

  function automatic state_e adv_state(input logic [AW-1:0] j_nxt,
                                       input logic [AW-1:0] s_nxt,
                                       input logic [AW-1:0] hi_v);
    return (j_nxt != hi_v) ? RDJ : ((s_nxt == hi_v) ? DONE : RDF);
  endfunction

  // Partition sequencing and datapath register updates.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    j_d     = j_q;
    s_d     = s_q;
    p_idx_d = p_idx_q;
    pivot_d = pivot_q;
    a_j_d   = a_j_q;
    a_s_d   = a_s_q;
    case (state_q)
      IDLE: begin
        if (start && (lo < hi)) begin
          lo_d    = lo;
          hi_d    = hi;
          state_d = RDP;
        end else if (start) begin
          p_idx_d = lo;
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      RDP: state_d = WP;
      WP: begin
        pivot_d = mem_rdata;
        s_d     = lo_q;
        j_d     = lo_q;
        state_d = RDJ;
      end
      RDJ: state_d = WJ;
      WJ: begin
        a_j_d = mem_rdata;
        if (!agrt && (s_q != j_q)) begin
          state_d = RDS;
        end else begin
          s_d     = agrt ? s_q : s_q + ONE;
          j_d     = j_q + ONE;
          state_d = adv_state(j_d, s_d, hi_q);
          p_idx_d = (state_d == DONE) ? s_d : p_idx_q;
        end
      end
      RDS: state_d = WS;
      WS: begin
        a_s_d   = mem_rdata;
        state_d = WRS;
      end
      WRS: state_d = WRJ;
      WRJ: begin
        s_d     = s_q + ONE;
        j_d     = j_q + ONE;
        state_d = adv_state(j_d, s_d, hi_q);
        p_idx_d = (state_d == DONE) ? s_d : p_idx_q;
      end
      RDF: state_d = WF;
      WF: begin
        a_s_d   = mem_rdata;
        state_d = WRF1;
      end
      WRF1: state_d = WRF2;
      WRF2: begin
        p_idx_d = s_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    re_d    = is_read_state(state_d);
    we_d    = is_write_state(state_d);
    addr_d  = '0;
    wdata_d = L'(POS_ZERO);
    case (state_d)
      RDP:  addr_d = hi_d;
      RDJ:  addr_d = j_d;
      RDS:  addr_d = s_d;
      RDF:  addr_d = s_d;
      WRS: begin
        addr_d  = s_d;
        wdata_d = a_j_d;
      end
      WRJ: begin
        addr_d  = j_d;
        wdata_d = a_s_d;
      end
      WRF1: begin
        addr_d  = s_d;
        wdata_d = pivot_d;
      end
      WRF2: begin
        addr_d  = hi_d;
        wdata_d = a_s_d;
      end
      default: addr_d = '0;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      j_q     <= '0;
      s_q     <= '0;
      p_idx_q <= '0;
      pivot_q <= '0;
      a_j_q   <= '0;
      a_s_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      j_q     <= j_d;
      s_q     <= s_d;
      p_idx_q <= p_idx_d;
      pivot_q <= pivot_d;
      a_j_q   <= a_j_d;
      a_s_q   <= a_s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      re_q    <= re_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign p_idx     = p_idx_q;
  assign mem_addr  = addr_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;

endmodule
